mem_stage: RTL and testbench

- Memory-access stage of the 64-bit in-order pipeline, directly downstream of the EX/MEM pipeline register.
- Consumes the registered `execute_data_t` (dataE) and drives the data-bus request/response handshake for loads and stores.
- Aligns store data and byte strobes; extracts and sign/zero-extends load data.
- Emits `memory_data_t` (dataM) toward MEM/WB and a stall that freezes all upstream stages while a bus transaction is outstanding.

---
 rtl/common_pkg.sv | 22 ++
 rtl/pipes_pkg.sv | 60 ++++++
 rtl/mem_align.sv | 61 ++++++
 rtl/mem_stage.sv | 140 ++++++++++++++
 tb/tb_mem_stage.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/common_pkg.sv
// Shared bus definitions for the data-memory port.
// Contents: data-bus request/response structs and the bus widths they use.
package common_pkg;

  localparam int BUS_XLEN   = 64;
  localparam int BUS_STRB_W = BUS_XLEN / 8;

  typedef struct packed {
    logic                  valid;
    logic [BUS_XLEN-1:0]   addr;
    logic [2:0]            size;
    logic [BUS_STRB_W-1:0] strobe;
    logic [BUS_XLEN-1:0]   data;
  } dbus_req_t;

  typedef struct packed {
    logic                addr_ok;
    logic                data_ok;
    logic [BUS_XLEN-1:0] data;
  } dbus_resp_t;

endpackage

// File: rtl/pipes_pkg.sv
// Pipeline-register payload types between EX, MEM and WB.
// Contents: msize_t access-size enum, mem_state_t bus FSM states,
// execute_data_t (EX/MEM) and memory_data_t (MEM/WB), plus size_mask().
package pipes_pkg;
  import common_pkg::*;

  typedef enum logic [1:0] {
    MSIZE1 = 2'd0,
    MSIZE2 = 2'd1,
    MSIZE4 = 2'd2,
    MSIZE8 = 2'd3
  } msize_t;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WAIT_ADDR = 2'd1,
    S_ADDR_ACK  = 2'd2
  } mem_state_t;

  typedef struct packed {
    logic   memread;
    logic   memwrite;
    msize_t msize;
    logic   mem_unsigned;
  } mem_ctl_t;

  typedef struct packed {
    logic                valid;
    logic [BUS_XLEN-1:0] pc;
    logic [31:0]         instr;
    mem_ctl_t            ctl;
    logic [BUS_XLEN-1:0] alu_result;
    logic [BUS_XLEN-1:0] rs2_data;
    logic [4:0]          dst;
    logic                regwrite;
  } execute_data_t;

  typedef struct packed {
    logic                valid;
    logic [BUS_XLEN-1:0] pc;
    logic [31:0]         instr;
    logic [4:0]          dst;
    logic                regwrite;
    logic [BUS_XLEN-1:0] wdata;
    logic [BUS_XLEN-1:0] addr;
    logic                exc_misalign;
    logic                exc_is_store;
  } memory_data_t;

  // Low address bits that must be zero for a naturally aligned access.
  function automatic logic [2:0] size_mask(msize_t s);
    case (s)
      MSIZE1:  return 3'b000;
      MSIZE2:  return 3'b001;
      MSIZE4:  return 3'b011;
      default: return 3'b111;
    endcase
  endfunction

endpackage

// File: rtl/mem_align.sv
// Combinational byte-lane logic for the data port: write strobes, store-data
// lane shift, and load-data extract with sign/zero extension.
// Ports: off_i (addr[2:0]), msize_i, mem_unsigned_i, st_data_i (rs2),
//        ld_raw_i (bus read word) -> strobe_o, st_data_o, ld_data_o.
// MEM_MISALIGN_TRAP_EN: when undefined, the offset is forced to natural
// alignment here; when defined, misaligned accesses never reach this block.
module mem_align
  import pipes_pkg::*;
#(
  parameter int XLEN   = 64,
  parameter int STRB_W = XLEN / 8
) (
  input  logic [2:0]        off_i,
  input  msize_t            msize_i,
  input  logic              mem_unsigned_i,
  input  logic [XLEN-1:0]   st_data_i,
  input  logic [XLEN-1:0]   ld_raw_i,
  output logic [STRB_W-1:0] strobe_o,
  output logic [XLEN-1:0]   st_data_o,
  output logic [XLEN-1:0]   ld_data_o
);

  logic [2:0]        off;
  logic [5:0]        bit_sh;
  logic [STRB_W-1:0] base;
  logic [XLEN-1:0]   ld_sh;

`ifdef MEM_MISALIGN_TRAP_EN
  assign off = off_i;
`else
  assign off = off_i & ~size_mask(msize_i);
`endif

  assign bit_sh = {off, 3'b000};

  always_comb begin
    case (msize_i)
      MSIZE1:  base = STRB_W'(8'h01);
      MSIZE2:  base = STRB_W'(8'h03);
      MSIZE4:  base = STRB_W'(8'h0F);
      default: base = STRB_W'(8'hFF);
    endcase
  end

  assign strobe_o  = base << off;
  assign st_data_o = st_data_i << bit_sh;
  assign ld_sh     = ld_raw_i >> bit_sh;

  always_comb begin
    case (msize_i)
      MSIZE1:  ld_data_o = mem_unsigned_i ? {{(XLEN-8){1'b0}}, ld_sh[7:0]}
                                          : {{(XLEN-8){ld_sh[7]}}, ld_sh[7:0]};
      MSIZE2:  ld_data_o = mem_unsigned_i ? {{(XLEN-16){1'b0}}, ld_sh[15:0]}
                                          : {{(XLEN-16){ld_sh[15]}}, ld_sh[15:0]};
      MSIZE4:  ld_data_o = mem_unsigned_i ? {{(XLEN-32){1'b0}}, ld_sh[31:0]}
                                          : {{(XLEN-32){ld_sh[31]}}, ld_sh[31:0]};
      default: ld_data_o = ld_sh;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: issues load/store requests on the data bus, holds the
// pipeline with stallM while a transaction is open, and produces the MEM/WB
// payload. Non-memory ops pass straight through with no added latency.
// Ports: clk, reset (sync, active-high), dataE (EX/MEM), dreq_* (bus request),
//        dresp_* (bus response), dataM (to MEM/WB), stallM.
// MEM_MISALIGN_TRAP_EN: defined -> misaligned accesses raise exc_misalign
// instead of going to the bus; undefined -> addresses are force-aligned.
module mem_stage
  import common_pkg::*;
  import pipes_pkg::*;
#(
  parameter int XLEN   = BUS_XLEN,
  parameter int STRB_W = XLEN / 8
) (
  input  logic              clk,
  input  logic              reset,
  input  execute_data_t     dataE,
  output logic              dreq_valid,
  output logic [XLEN-1:0]   dreq_addr,
  output logic [2:0]        dreq_size,
  output logic [STRB_W-1:0] dreq_strobe,
  output logic [XLEN-1:0]   dreq_data,
  input  logic              dresp_addr_ok,
  input  logic              dresp_data_ok,
  input  logic [XLEN-1:0]   dresp_data,
  output memory_data_t      dataM,
  output logic              stallM
);

  mem_state_t        state_q, state_d;
  execute_data_t     req_q, req_d;
  execute_data_t     src;
  dbus_resp_t        resp;
  logic              is_mem_e, mis_e, busy, issue, done;
  logic [STRB_W-1:0] strobe;
  logic [XLEN-1:0]   st_data, ld_data;

  assign resp = '{addr_ok: dresp_addr_ok, data_ok: dresp_data_ok, data: dresp_data};

  assign is_mem_e = dataE.valid & (dataE.ctl.memread | dataE.ctl.memwrite);

`ifdef MEM_MISALIGN_TRAP_EN
  assign mis_e = is_mem_e & (|(dataE.alu_result[2:0] & size_mask(dataE.ctl.msize)));
`else
  assign mis_e = 1'b0;
`endif

  assign busy  = (state_q != S_IDLE);
  assign issue = ~busy & is_mem_e & ~mis_e;

  // The request is presented from dataE on the issue cycle and from the
  // latched copy afterwards, so upstream changes cannot disturb the bus.
  assign src  = busy ? req_q : dataE;
  assign done = (issue | busy) & resp.data_ok & (resp.addr_ok | (state_q == S_ADDR_ACK));

  mem_align #(.XLEN(XLEN), .STRB_W(STRB_W)) u_align (
    .off_i          (src.alu_result[2:0]),
    .msize_i        (src.ctl.msize),
    .mem_unsigned_i (src.ctl.mem_unsigned),
    .st_data_i      (src.rs2_data),
    .ld_raw_i       (resp.data),
    .strobe_o       (strobe),
    .st_data_o      (st_data),
    .ld_data_o      (ld_data)
  );

  assign dreq_valid  = issue | busy;
  assign dreq_addr   = src.alu_result;
  assign dreq_size   = {1'b0, src.ctl.msize};
  assign dreq_strobe = src.ctl.memwrite ? strobe : '0;
  assign dreq_data   = st_data;
  assign stallM      = dreq_valid & ~done;

  always_comb begin
    dataM = '0;
    if (dreq_valid) begin
      if (done) begin
        dataM.valid    = 1'b1;
        dataM.pc       = src.pc;
        dataM.instr    = src.instr;
        dataM.dst      = src.dst;
        dataM.addr     = src.alu_result;
        dataM.regwrite = src.regwrite & ~src.ctl.memwrite;
        dataM.wdata    = src.ctl.memwrite ? '0 : ld_data;
      end
    end else if (mis_e) begin
      // Trap: report the faulting address as mtval in wdata.
      dataM.valid        = 1'b1;
      dataM.pc           = dataE.pc;
      dataM.instr        = dataE.instr;
      dataM.dst          = dataE.dst;
      dataM.wdata        = dataE.alu_result;
      dataM.addr         = dataE.alu_result;
      dataM.exc_misalign = 1'b1;
      dataM.exc_is_store = dataE.ctl.memwrite;
    end else begin
      dataM.valid    = dataE.valid;
      dataM.pc       = dataE.pc;
      dataM.instr    = dataE.instr;
      dataM.dst      = dataE.dst;
      dataM.regwrite = dataE.regwrite;
      dataM.wdata    = dataE.alu_result;
      dataM.addr     = dataE.alu_result;
    end
  end

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    case (state_q)
      S_IDLE: begin
        if (issue) begin
          req_d = dataE;
          if (resp.addr_ok & resp.data_ok) state_d = S_IDLE;
          else if (resp.addr_ok)           state_d = S_ADDR_ACK;
          else                             state_d = S_WAIT_ADDR;
        end
      end
      S_WAIT_ADDR: begin
        if (resp.addr_ok & resp.data_ok) state_d = S_IDLE;
        else if (resp.addr_ok)           state_d = S_ADDR_ACK;
      end
      S_ADDR_ACK: begin
        if (resp.data_ok) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      req_q   <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: loads, stores, single-cycle bus response,
// pass-through ALU op, reset mid-transaction, and alignment handling.
module tb_mem_stage;
  import common_pkg::*;
  import pipes_pkg::*;

  logic          clk = 1'b0;
  logic          reset;
  execute_data_t dataE;
  logic          dreq_valid;
  logic [63:0]   dreq_addr;
  logic [2:0]    dreq_size;
  logic [7:0]    dreq_strobe;
  logic [63:0]   dreq_data;
  logic          dresp_addr_ok;
  logic          dresp_data_ok;
  logic [63:0]   dresp_data;
  memory_data_t  dataM;
  logic          stallM;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk           (clk),
    .reset         (reset),
    .dataE         (dataE),
    .dreq_valid    (dreq_valid),
    .dreq_addr     (dreq_addr),
    .dreq_size     (dreq_size),
    .dreq_strobe   (dreq_strobe),
    .dreq_data     (dreq_data),
    .dresp_addr_ok (dresp_addr_ok),
    .dresp_data_ok (dresp_data_ok),
    .dresp_data    (dresp_data),
    .dataM         (dataM),
    .stallM        (stallM)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  function automatic execute_data_t mk(input logic rd, input logic wr, input msize_t sz,
                                       input logic uns, input logic [63:0] addr,
                                       input logic [63:0] rs2, input logic rw);
    execute_data_t e;
    e = '0;
    e.valid            = 1'b1;
    e.pc               = 64'h1000;
    e.instr            = 32'h0000_0013;
    e.ctl.memread      = rd;
    e.ctl.memwrite     = wr;
    e.ctl.msize        = sz;
    e.ctl.mem_unsigned = uns;
    e.alu_result       = addr;
    e.rs2_data         = rs2;
    e.dst              = 5'd5;
    e.regwrite         = rw;
    return e;
  endfunction

  initial begin
    reset = 1'b1; dataE = '0;
    dresp_addr_ok = 1'b0; dresp_data_ok = 1'b0; dresp_data = '0;
    tick(); tick();
    reset = 1'b0; #1;
    chk("rst_dreq_valid", {63'b0, dreq_valid}, 64'd0);
    chk("rst_stall",      {63'b0, stallM},     64'd0);
    chk("rst_dataM_zero", {63'b0, (dataM === memory_data_t'('0))}, 64'd1);
    tick();

    // LD: addr_ok one cycle after issue, data_ok three cycles after that
    dataE = mk(1'b1, 1'b0, MSIZE8, 1'b0, 64'h8000_1008, 64'h0, 1'b1); #1;
    chk("ld_c0_valid",  {63'b0, dreq_valid}, 64'd1);
    chk("ld_c0_addr",   dreq_addr, 64'h8000_1008);
    chk("ld_c0_size",   {61'b0, dreq_size}, 64'd3);
    chk("ld_c0_strobe", {56'b0, dreq_strobe}, 64'd0);
    chk("ld_c0_stall",  {63'b0, stallM}, 64'd1);
    chk("ld_c0_bubble", {63'b0, dataM.valid}, 64'd0);
    tick();
    dresp_addr_ok = 1'b1; #1;
    chk("ld_c1_stall", {63'b0, stallM}, 64'd1);
    tick();
    dresp_addr_ok = 1'b0; dataE.alu_result = 64'h0BAD_0000; #1;
    chk("ld_c2_addr_held", dreq_addr, 64'h8000_1008);
    chk("ld_c2_size_held", {61'b0, dreq_size}, 64'd3);
    chk("ld_c2_valid",     {63'b0, dreq_valid}, 64'd1);
    chk("ld_c2_stall",     {63'b0, stallM}, 64'd1);
    tick(); #1;
    chk("ld_c3_stall", {63'b0, stallM}, 64'd1);
    tick();
    dresp_data_ok = 1'b1; dresp_data = 64'hDEAD_BEEF_CAFE_F00D; #1;
    chk("ld_c4_stall", {63'b0, stallM}, 64'd0);
    chk("ld_c4_valid", {63'b0, dataM.valid}, 64'd1);
    chk("ld_c4_wdata", dataM.wdata, 64'hDEAD_BEEF_CAFE_F00D);
    chk("ld_c4_rw",    {63'b0, dataM.regwrite}, 64'd1);
    chk("ld_c4_addr",  dataM.addr, 64'h8000_1008);
    tick();

    // LB / LBU completing in the issue cycle, back-to-back after the LD
    dataE = mk(1'b1, 1'b0, MSIZE1, 1'b0, 64'h8000_0005, 64'h0, 1'b1);
    dresp_addr_ok = 1'b1; dresp_data_ok = 1'b1; dresp_data = 64'h0000_8000_0000_0000; #1;
    chk("lb_strobe", {56'b0, dreq_strobe}, 64'd0);
    chk("lb_size",   {61'b0, dreq_size}, 64'd0);
    chk("lb_stall",  {63'b0, stallM}, 64'd0);
    chk("lb_valid",  {63'b0, dataM.valid}, 64'd1);
    chk("lb_wdata",  dataM.wdata, 64'hFFFF_FFFF_FFFF_FF80);
    tick();
    dataE.ctl.mem_unsigned = 1'b1; #1;
    chk("lbu_stall", {63'b0, stallM}, 64'd0);
    chk("lbu_wdata", dataM.wdata, 64'h0000_0000_0000_0080);
    tick();

    // ADD straight after single-cycle loads: zero-latency pass-through
    dresp_addr_ok = 1'b0; dresp_data_ok = 1'b0;
    dataE = mk(1'b0, 1'b0, MSIZE8, 1'b0, 64'h42, 64'h0, 1'b1); #1;
    chk("add_stall",  {63'b0, stallM}, 64'd0);
    chk("add_dreq",   {63'b0, dreq_valid}, 64'd0);
    chk("add_valid",  {63'b0, dataM.valid}, 64'd1);
    chk("add_wdata",  dataM.wdata, 64'h42);
    chk("add_rw",     {63'b0, dataM.regwrite}, 64'd1);
    tick();

    // SH: accepted at issue, completes next cycle
    dataE = mk(1'b0, 1'b1, MSIZE2, 1'b0, 64'h8000_0002, 64'h1234, 1'b1);
    dresp_addr_ok = 1'b1; #1;
    chk("sh_strobe", {56'b0, dreq_strobe}, 64'h0C);
    chk("sh_data",   dreq_data, 64'h0000_0000_1234_0000);
    chk("sh_stall",  {63'b0, stallM}, 64'd1);
    tick();
    dresp_addr_ok = 1'b0; dresp_data_ok = 1'b1; #1;
    chk("sh_done_stall", {63'b0, stallM}, 64'd0);
    chk("sh_done_valid", {63'b0, dataM.valid}, 64'd1);
    chk("sh_done_rw",    {63'b0, dataM.regwrite}, 64'd0);
    chk("sh_done_wdata", dataM.wdata, 64'd0);
    tick();

    // Reset while in ADDR_ACK, then a stray data_ok
    dresp_data_ok = 1'b0;
    dataE = mk(1'b1, 1'b0, MSIZE4, 1'b0, 64'h8000_0004, 64'h0, 1'b1);
    dresp_addr_ok = 1'b1; #1;
    chk("rs_issue_stall", {63'b0, stallM}, 64'd1);
    tick();
    dresp_addr_ok = 1'b0; reset = 1'b1; dataE = '0;
    tick();
    reset = 1'b0; dresp_data_ok = 1'b1; dresp_data = 64'h1111_2222_3333_4444; #1;
    chk("rs_dreq_valid", {63'b0, dreq_valid}, 64'd0);
    chk("rs_stall",      {63'b0, stallM}, 64'd0);
    chk("rs_dataM_zero", {63'b0, (dataM === memory_data_t'('0))}, 64'd1);
    tick();
    dresp_data_ok = 1'b0; #1;
    chk("rs_after_valid", {63'b0, dreq_valid}, 64'd0);
    tick();

`ifdef MEM_MISALIGN_TRAP_EN
    dataE = mk(1'b1, 1'b0, MSIZE4, 1'b0, 64'h8000_0006, 64'h0, 1'b1); #1;
    chk("mis_dreq",  {63'b0, dreq_valid}, 64'd0);
    chk("mis_stall", {63'b0, stallM}, 64'd0);
    chk("mis_valid", {63'b0, dataM.valid}, 64'd1);
    chk("mis_exc",   {63'b0, dataM.exc_misalign}, 64'd1);
    chk("mis_store", {63'b0, dataM.exc_is_store}, 64'd0);
    chk("mis_rw",    {63'b0, dataM.regwrite}, 64'd0);
    chk("mis_wdata", dataM.wdata, 64'h8000_0006);
`else
    // Misaligned SW is forced to the aligned word at offset 4
    dataE = mk(1'b0, 1'b1, MSIZE4, 1'b0, 64'h8000_0006, 64'hAABB_CCDD, 1'b1);
    dresp_addr_ok = 1'b1; dresp_data_ok = 1'b1; #1;
    chk("al_dreq",   {63'b0, dreq_valid}, 64'd1);
    chk("al_strobe", {56'b0, dreq_strobe}, 64'hF0);
    chk("al_data",   dreq_data, 64'hAABB_CCDD_0000_0000);
    chk("al_addr",   dreq_addr, 64'h8000_0006);
    chk("al_exc",    {63'b0, dataM.exc_misalign}, 64'd0);
    tick();
    dataE = mk(1'b1, 1'b0, MSIZE4, 1'b0, 64'h8000_0006, 64'h0, 1'b1);
    dresp_data = 64'h1122_3344_5566_7788; #1;
    chk("al_lw_wdata", dataM.wdata, 64'h0000_0000_1122_3344);
`endif
    tick();
    dresp_addr_ok = 1'b0; dresp_data_ok = 1'b0; dataE = '0;
    tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
